// File: rtl/cdc_handshake_src.sv
// Source side of a multi-bit CDC using a 4-phase req/ack handshake.
// A word accepted on in_valid/in_ready is held on xfer_data while xfer_req
// is raised. The return-to-zero phase is sequenced from a synchronised copy
// of the destination ack. A watchdog gives up on a dead destination.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new word (unless a stale ack is still visible)
// REQ   | xfer_req high, waiting for the synchronised ack to rise
// DROP  | xfer_req low, waiting for the synchronised ack to fall
// ERR   | timed out; xfer_req low, waiting for the ack to be low
module cdc_handshake_src #(
  parameter int S           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [S-1:0] in_data,
  output logic         xfer_req,
  output logic [S-1:0] xfer_data,
  input  logic         xfer_ack_async,
  output logic         busy,
  output logic         timeout_err,
  input  logic         err_clr
);

  // The counter only has to reach TIMEOUT_CYC-1; a disabled watchdog keeps a 1-bit stub.
  localparam int            CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit            TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [CW-1:0]          cnt_q;
  logic                   accept;
  logic                   to_hit;
  logic                   to_fire;

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign in_ready = (state_q == IDLE) && !ack_s;
  assign busy     = (state_q != IDLE);

  // Ack synchroniser: every FSM decision looks only at the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], xfer_ack_async};
    end
  end

  // Next-state decode, including the watchdog escape from REQ and DROP.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    to_fire   = 1'b0;
    to_hit    = TO_EN && (cnt_q == TO_LAST);
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_nxt = DROP;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = ERR;
        end
      end
      DROP: begin
        if (!ack_s) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = ERR;
        end
      end
      ERR: begin
        if (!ack_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; xfer_req is registered straight from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      xfer_req <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      xfer_req <= (state_nxt == REQ);
    end
  end

  // Captured word only changes on accept, so it survives the return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_data <= '0;
    end else if (accept) begin
      xfer_data <= in_data;
    end
  end

  // Dwell counter: restarts on any state change, counts while in REQ or DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_nxt != state_q) begin
      cnt_q <= '0;
    end else if ((state_q == REQ) || (state_q == DROP)) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (to_fire) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Bench for cdc_handshake_src: one instance with a 10-cycle watchdog and one
// with the watchdog disabled. Stimulus pushes expected words; a forked
// monitor pops them whenever xfer_req rises and checks the captured word.
module tb_cdc_handshake_src;

  logic       clk;
  logic       rst;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic       a_in_valid, a_in_ready, a_xfer_req, a_busy, a_timeout_err, a_err_clr;
  logic [7:0] a_in_data, a_xfer_data;
  logic       a_ack, a_man_ack, a_auto;
  logic       b_in_valid, b_in_ready, b_xfer_req, b_busy, b_timeout_err, b_err_clr;
  logic [7:0] b_in_data, b_xfer_data;
  logic       b_ack;

  logic [7:0] a_exp_q[$];
  logic [7:0] b_exp_q[$];
  int         a_acc_cyc[$];

  // Immediate-response destination model when a_auto is set.
  assign a_ack = a_auto ? a_xfer_req : a_man_ack;

  cdc_handshake_src #(.S(8), .SYNC_STAGES(2), .TIMEOUT_CYC(10)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (a_in_valid),
    .in_ready       (a_in_ready),
    .in_data        (a_in_data),
    .xfer_req       (a_xfer_req),
    .xfer_data      (a_xfer_data),
    .xfer_ack_async (a_ack),
    .busy           (a_busy),
    .timeout_err    (a_timeout_err),
    .err_clr        (a_err_clr)
  );

  cdc_handshake_src #(.S(8), .SYNC_STAGES(2), .TIMEOUT_CYC(0)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (b_in_valid),
    .in_ready       (b_in_ready),
    .in_data        (b_in_data),
    .xfer_req       (b_xfer_req),
    .xfer_data      (b_xfer_data),
    .xfer_ack_async (b_ack),
    .busy           (b_busy),
    .timeout_err    (b_timeout_err),
    .err_clr        (b_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a rising xfer_req marks an accept.
  task automatic monitor();
    logic       a_prev = 1'b0;
    logic       b_prev = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (a_xfer_req && !a_prev) begin
        if (a_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_accept: got data %0h, expected no accept", a_xfer_data);
        end else begin
          e = a_exp_q.pop_front();
          check("a_accept_data", a_xfer_data, e);
          a_acc_cyc.push_back(cyc);
        end
      end
      if (b_xfer_req && !b_prev) begin
        if (b_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_accept: got data %0h, expected no accept", b_xfer_data);
        end else begin
          e = b_exp_q.pop_front();
          check("b_accept_data", b_xfer_data, e);
        end
      end
      a_prev = a_xfer_req;
      b_prev = b_xfer_req;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_man_ack = 0; a_auto = 0; a_err_clr = 0;
    b_in_valid = 0; b_in_data = 0; b_ack = 0; b_err_clr = 0;
    fork
      monitor();
    join_none
    #3;
    check("rst_req", a_xfer_req, 0);
    check("rst_busy", a_busy, 0);
    check("rst_data", a_xfer_data, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_terr", a_timeout_err, 0);
    check("rst_b_ready", b_in_ready, 1);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset asserted in the middle of REQ acts without a clock edge.
    a_in_data = 8'h99; a_in_valid = 1; a_exp_q.push_back(8'h99);
    step();
    a_in_valid = 0;
    check("mid_req_up", a_xfer_req, 1);
    repeat (2) step();
    #3 rst = 1'b1;
    #1;
    check("midrst_req", a_xfer_req, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_data", a_xfer_data, 0);
    check("midrst_ready", a_in_ready, 1);
    step();
    rst = 1'b0;
    step();

    // Single transfer with exact ack latencies.
    a_in_data = 8'hA5; a_in_valid = 1; a_exp_q.push_back(8'hA5);
    step();
    a_in_valid = 0;
    check("single_req", a_xfer_req, 1);
    check("single_data", a_xfer_data, 8'hA5);
    repeat (2) step();
    a_man_ack = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("ackrise_req", a_xfer_req, (i < 3));
    end
    a_man_ack = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("ackfall_ready", a_in_ready, (i == 3));
    end
    check("single_data_hold", a_xfer_data, 8'hA5);

    // Back-to-back words with an immediate destination.
    a_acc_cyc.delete();
    a_auto = 1;
    a_in_valid = 1;
    for (int w = 1; w <= 3; w++) begin
      a_in_data = 8'(w);
      a_exp_q.push_back(8'(w));
      n = 0;
      while (!a_in_ready && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) check("b2b_ready_wait", 0, 1);
      step();
    end
    a_in_valid = 0;
    n = 0;
    while (a_busy && n < 50) begin
      step();
      n++;
    end
    check("b2b_idle_wait", (n < 50), 1);
    a_auto = 0;
    step();
    check("b2b_count", a_acc_cyc.size(), 3);
    check("b2b_queue_empty", a_exp_q.size(), 0);
    if (a_acc_cyc.size() == 3) begin
      check("b2b_period1", a_acc_cyc[1] - a_acc_cyc[0], 7);
      check("b2b_period2", a_acc_cyc[2] - a_acc_cyc[1], 7);
    end
    check("b2b_last_data", a_xfer_data, 8'h03);

    // Stale ack blocks accepts until it has been synchronised low.
    a_man_ack = 1;
    repeat (3) step();
    check("stale_ready", a_in_ready, 0);
    a_in_data = 8'h3C; a_in_valid = 1;
    repeat (5) step();
    check("stale_busy", a_busy, 0);
    check("stale_ready2", a_in_ready, 0);
    a_exp_q.push_back(8'h3C);
    a_man_ack = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("stale_accept", a_xfer_req, (i == 3));
    end
    a_in_valid = 0;
    a_man_ack = 1;
    n = 0;
    while (a_xfer_req && n < 20) begin step(); n++; end
    check("stale_drop_wait", (n < 20), 1);
    a_man_ack = 0;
    n = 0;
    while (!a_in_ready && n < 20) begin step(); n++; end
    check("stale_idle_wait", (n < 20), 1);

    // Watchdog fires 10 cycles after entering REQ.
    a_in_data = 8'h77; a_in_valid = 1; a_exp_q.push_back(8'h77);
    step();
    a_in_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("to_req", a_xfer_req, (i < 10));
      check("to_flag", a_timeout_err, (i == 10));
    end
    check("to_err_busy", a_busy, 1);
    step();
    check("to_back_idle", a_busy, 0);
    check("to_sticky", a_timeout_err, 1);
    a_err_clr = 1;
    step();
    a_err_clr = 0;
    check("to_cleared", a_timeout_err, 0);
    a_in_data = 8'h78; a_in_valid = 1; a_exp_q.push_back(8'h78);
    step();
    a_in_valid = 0;
    repeat (9) step();
    check("to_pre_flag", a_timeout_err, 0);
    a_err_clr = 1;
    step();
    a_err_clr = 0;
    check("to_set_wins", a_timeout_err, 1);
    check("to_set_req", a_xfer_req, 0);
    step();
    check("to_idle2", a_busy, 0);
    a_err_clr = 1;
    step();
    a_err_clr = 0;
    check("to_cleared2", a_timeout_err, 0);

    // Disabled watchdog: REQ is held indefinitely.
    b_in_data = 8'h5A; b_in_valid = 1; b_exp_q.push_back(8'h5A);
    step();
    b_in_valid = 0;
    repeat (1000) step();
    check("noto_busy", b_busy, 1);
    check("noto_req", b_xfer_req, 1);
    check("noto_flag", b_timeout_err, 0);
    check("noto_data", b_xfer_data, 8'h5A);
    b_ack = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("noto_ackrise", b_xfer_req, (i < 3));
    end
    b_ack = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("noto_ackfall", b_in_ready, (i == 3));
    end
    check("noto_flag_end", b_timeout_err, 0);

    step();
    check("a_queue_empty", a_exp_q.size(), 0);
    check("b_queue_empty", b_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_src.md
Name: cdc_handshake_src

Overview:
- Source-side controller for a multi-bit clock-domain crossing using a 4-phase req/ack handshake.
- Accepts a word via valid/ready and holds it stable on xfer_data.
- Raises xfer_req, then sequences the return-to-zero phase using an ack synchronised internally through a SYNC_STAGES-deep flop chain.
- Sits in the sending clock domain. The destination samples xfer_data only while req is high. Includes a timeout watchdog for a dead destination.

Parameters:
- S, 8, data width in bits.
- SYNC_STAGES, 2, ack synchroniser depth; legal values are 2 or more.
- TIMEOUT_CYC, 255, maximum cycles spent in REQ or DROP before an error; 0 disables the timeout.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  S  upstream word.
- xfer_req  output  1  4-phase request to the destination domain; registered.
- xfer_data  output  S  captured word; registered and stable while busy.
- xfer_ack_async  input  1  ack from the destination domain; asynchronous to clk.
- busy  output  1  handshake in progress (state is not IDLE).
- timeout_err  output  1  sticky error flag.
- err_clr  input  1  clears timeout_err.

Behaviour:
- Reset (async, rst=1): state=IDLE, sync chain=0, xfer_req=0, xfer_data=0, timeout_err=0, counter=0. Outputs update immediately on rst assertion. Reset mid-handshake drops xfer_req at once; the destination must tolerate this.
- ack_s is the last stage of the SYNC_STAGES flop chain on xfer_ack_async. All FSM decisions use ack_s only, never the raw input.
- in_ready = (state==IDLE) && !ack_s. It is decoded from registers only, with no combinational path from in_valid.
- Accept: the edge at which in_valid && in_ready is sampled. At that edge xfer_data <= in_data, xfer_req <= 1, state <= REQ.
- xfer_data changes only on accept, so it holds its value after return to IDLE.
- FSM states: IDLE, REQ, DROP, ERR.
  - IDLE -> REQ on accept.
  - REQ: xfer_req=1. If ack_s=1: state <= DROP, xfer_req <= 0.
  - DROP: xfer_req=0. If ack_s=0: state <= IDLE.
  - ERR: xfer_req=0. If ack_s=0: state <= IDLE.
- Timeout:
  - The counter clears on every state change.
  - It increments each cycle spent in REQ or DROP.
  - If TIMEOUT_CYC != 0 and the counter == TIMEOUT_CYC-1 while the exit condition is false, then at the next edge: state <= ERR, xfer_req <= 0, timeout_err <= 1.
  - Counter width is clog2(TIMEOUT_CYC+1), minimum 1.
- timeout_err is sticky and cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Latency:
  - Accept to xfer_req high: 1 edge.
  - ack rise to xfer_req low: SYNC_STAGES+1 edges.
  - ack fall to in_ready high: SYNC_STAGES+1 edges.
  - Minimum transfer period: 2*SYNC_STAGES+3 clk cycles, assuming an instantaneous destination.
- Stale ack (ack_s=1 while in IDLE): in_ready=0 and no accept until ack_s returns to 0.
- in_valid while busy: ignored. Upstream holds in_data until in_ready is high.
- busy = (state != IDLE), registered decode.

Test Plan:
- Reset check: assert rst mid-REQ -> xfer_req=0, busy=0, xfer_data=0, in_ready=1 without waiting for a clk edge.
- Single transfer, S=8, SYNC_STAGES=2: in_data=0xA5 with in_valid for 1 cycle -> xfer_data=0xA5 and xfer_req=1 after 1 edge. A model asserts ack 2 cycles later -> xfer_req=0 exactly 3 edges after the ack rise. Ack drops -> in_ready=1 3 edges later. xfer_data stays 0xA5 throughout.
- Back-to-back transfers: in_valid held high with 0x01, 0x02, 0x03 -> three handshakes, each word captured once, in order, never two accepts in one handshake. Period is 7 cycles with an immediate-response ack model.
- Stale ack: xfer_ack_async=1 out of reset with in_valid=1 -> in_ready=0 and no accept. Release ack -> accept occurs 3 edges later.
- Timeout, TIMEOUT_CYC=10, ack never rises: -> ERR and timeout_err=1 exactly 10 cycles after entering REQ, xfer_req=0, return to IDLE. Pulse err_clr -> flag clears. err_clr in the same cycle as a new timeout -> flag stays 1.
- Timeout disabled (TIMEOUT_CYC=0): ack withheld for 1000 cycles -> stays in REQ, timeout_err=0. Ack then completes the handshake normally.
